// File: rtl/dma_bus_arbiter_pkg.sv
// rtl/dma_bus_arbiter_pkg.sv - shared state encodings and sizes for the DMA bus arbiter
package dma_bus_arbiter_pkg;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_GRANT    = 2'b01,
      ST_HANDOVER = 2'b10
   } arb_state_t;
endpackage

// File: rtl/dma_bus_arbiter_rr_pick.sv
// rtl/dma_bus_arbiter_rr_pick.sv - combinational round-robin pick starting after last_id
module rr_pick
   import dma_bus_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last_id,
   output logic               any,
   output logic [ID_W-1:0]    winner_id,
   output logic [NUM_REQ-1:0] winner_onehot
);

   logic [ID_W-1:0] idx;

   // Walk from the farthest offset down so the nearest requester after last_id wins.
   always_comb begin
      any       = 1'b0;
      winner_id = '0;
      idx       = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = last_id + ID_W'(i);
         if (req[idx]) begin
            any       = 1'b1;
            winner_id = idx;
         end
      end
      winner_onehot = any ? (NUM_REQ'(1) << winner_id) : '0;
   end

endmodule

// File: rtl/dma_bus_arbiter.sv
// rtl/dma_bus_arbiter.sv - round-robin DMA bus arbiter, optional hold timeout via DMA_ARB_TIMEOUT_EN
module dma_bus_arbiter
   import dma_bus_arbiter_pkg::*;
#(
   parameter int HOLD_MAX = 15,
   parameter int CNT_W    = 4
)
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_valid,
   output logic [ID_W-1:0]    grant_id,
   output logic               timeout
);

   if ((1 << CNT_W) <= HOLD_MAX) begin : g_bad_cnt_w
      $error("CNT_W too narrow to reach HOLD_MAX");
   end

   arb_state_t         state, state_nxt;
   logic [ID_W-1:0]    last_id, last_id_nxt, grant_id_nxt;
   logic [NUM_REQ-1:0] grant_nxt;
   logic               grant_valid_nxt;
   logic               pick_any;
   logic [ID_W-1:0]    pick_id;
   logic [NUM_REQ-1:0] pick_onehot;
   logic               hold_req, hold_expired;

   rr_pick u_rr_pick (
      .req           (req),
      .last_id       (last_id),
      .any           (pick_any),
      .winner_id     (pick_id),
      .winner_onehot (pick_onehot)
   );

   assign hold_req = req[grant_id];

`ifdef DMA_ARB_TIMEOUT_EN
   logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
   logic             timeout_q, timeout_nxt;

   assign hold_expired = (hold_cnt == CNT_W'(HOLD_MAX));
   // A master that drops req on the expiry cycle releases normally, no pulse.
   assign timeout_nxt  = (state == ST_GRANT) && hold_req && hold_expired;
   assign timeout      = timeout_q;

   always_comb begin
      hold_cnt_nxt = hold_cnt + CNT_W'(1);
      if (state != ST_GRANT) hold_cnt_nxt = '0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hold_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_cnt  <= hold_cnt_nxt;
         timeout_q <= timeout_nxt;
      end
   end
`else
   assign hold_expired = 1'b0;
   assign timeout      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         grant       <= '0;
         grant_valid <= 1'b0;
         grant_id    <= '0;
         last_id     <= ID_W'(NUM_REQ - 1);
      end else begin
         state       <= state_nxt;
         grant       <= grant_nxt;
         grant_valid <= grant_valid_nxt;
         grant_id    <= grant_id_nxt;
         last_id     <= last_id_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_HANDOVER: state_nxt = pick_any ? ST_GRANT : ST_IDLE;
         ST_GRANT:             if (!hold_req || hold_expired) state_nxt = ST_HANDOVER;
         default:              state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      grant_nxt       = '0;
      grant_valid_nxt = 1'b0;
      grant_id_nxt    = '0;
      last_id_nxt     = last_id;
      if (state_nxt == ST_GRANT) begin
         grant_valid_nxt = 1'b1;
         if (state == ST_GRANT) begin
            grant_nxt    = grant;
            grant_id_nxt = grant_id;
         end else begin
            grant_nxt    = pick_onehot;
            grant_id_nxt = pick_id;
            last_id_nxt  = pick_id;
         end
      end
   end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb/tb_dma_bus_arbiter.sv - directed self-checking bench for dma_bus_arbiter
module tb_dma_bus_arbiter;

   localparam int HOLD = 15;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] req;
   logic [3:0] grant;
   logic       grant_valid;
   logic [1:0] grant_id;
   logic       timeout;
   logic       mon_en = 1'b0;
   int         n_checks = 0;
   int         n_errors = 0;

   dma_bus_arbiter #(.HOLD_MAX(HOLD), .CNT_W(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req         (req),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] id_of(input logic [3:0] g);
      logic [31:0] r;
      r = 0;
      for (int b = 0; b < 4; b++) if (g[b]) r = b;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [3:0] g, input logic to);
      check_val({tag, ".grant"}, {28'b0, grant}, {28'b0, g});
      check_val({tag, ".valid"}, {31'b0, grant_valid}, {31'b0, |g});
      check_val({tag, ".id"}, {30'b0, grant_id}, id_of(g));
      check_val({tag, ".timeout"}, {31'b0, timeout}, {31'b0, to});
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         check_val("mon.onehot0", {31'b0, $onehot0(grant)}, 32'd1);
         check_val("mon.valid", {31'b0, grant_valid}, {31'b0, |grant});
         check_val("mon.id", {30'b0, grant_id}, id_of(grant));
      end
   end

   initial begin
      reset_n = 1'b0;
      req     = 4'b0000;
      step();
      step();
      mon_en = 1'b1;
      expect_out("reset", 4'b0000, 1'b0);
      reset_n = 1'b1;

      // single master, one-cycle latency, stable hold
      req = 4'b0001;
      step();
      expect_out("single.first", 4'b0001, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step();
         expect_out("single.hold", 4'b0001, 1'b0);
      end
      req = 4'b0000;
      step();
      expect_out("single.handover", 4'b0000, 1'b0);
      step();
      expect_out("single.idle", 4'b0000, 1'b0);

      // fresh reset so master 0 leads the full rotation
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      req = 4'b1111;
      for (int m = 0; m < 4; m++) begin
         for (int k = 0; k < 3; k++) begin
            step();
            expect_out($sformatf("rr.m%0d", m), 4'b0001 << m, 1'b0);
         end
         req[m] = 1'b0;
         step();
         expect_out($sformatf("rr.gap%0d", m), 4'b0000, 1'b0);
      end
      step();
      expect_out("rr.idle", 4'b0000, 1'b0);

      // wrap-around: after master 2, master 0 beats re-requesting master 2
      req = 4'b0100;
      step();
      expect_out("wrap.m2", 4'b0100, 1'b0);
      req = 4'b0000;
      step();
      expect_out("wrap.gap", 4'b0000, 1'b0);
      req = 4'b0101;
      step();
      expect_out("wrap.m0", 4'b0001, 1'b0);
      req = 4'b0100;
      step();
      expect_out("wrap.gap2", 4'b0000, 1'b0);
      step();
      expect_out("wrap.m2_alone", 4'b0100, 1'b0);

      // other requests ignored while granted, then next pick after master 2 is 3
      req = 4'b1111;
      step();
      expect_out("nopreempt", 4'b0100, 1'b0);
      req = 4'b1011;
      step();
      expect_out("nopreempt.gap", 4'b0000, 1'b0);
      step();
      expect_out("nopreempt.m3", 4'b1000, 1'b0);
      req = 4'b0000;
      step();
      step();
      expect_out("nopreempt.idle", 4'b0000, 1'b0);

      // reset mid-grant
      req = 4'b0010;
      step();
      expect_out("midrst.m1", 4'b0010, 1'b0);
      reset_n = 1'b0;
      step();
      expect_out("midrst.reset", 4'b0000, 1'b0);
      reset_n = 1'b1;
      req = 4'b1000;
      step();
      expect_out("midrst.m3", 4'b1000, 1'b0);
      req = 4'b0000;
      step();
      step();

`ifdef DMA_ARB_TIMEOUT_EN
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      req = 4'b0010;
      for (int k = 0; k <= HOLD; k++) begin
         step();
         expect_out("to.hold1", 4'b0010, 1'b0);
      end
      step();
      expect_out("to.pulse1", 4'b0000, 1'b1);
      step();
      expect_out("to.regrant", 4'b0010, 1'b0);
      req = 4'b1010;
      for (int k = 1; k <= HOLD; k++) begin
         step();
         expect_out("to.hold2", 4'b0010, 1'b0);
      end
      step();
      expect_out("to.pulse2", 4'b0000, 1'b1);
      step();
      expect_out("to.m3", 4'b1000, 1'b0);
      for (int k = 1; k <= HOLD; k++) begin
         step();
         expect_out("to.hold3", 4'b1000, 1'b0);
      end
      // release coincides with expiry: plain handover
      req = 4'b0010;
      step();
      expect_out("to.release", 4'b0000, 1'b0);
      step();
      expect_out("to.m1", 4'b0010, 1'b0);
      req = 4'b0000;
      step();
      step();
`endif

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dma_bus_arbiter.md
DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 15: maximum cycles a master may hold grant (used only with ARB_TIMEOUT_EN).
REQ-002 Parameter CNT_W, default 4: hold-counter width; SHALL satisfy 2^CNT_W > HOLD_MAX.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  4  per-master bus request; level-held for the whole transfer.
REQ-006 grant  output  4  one-hot bus grant, registered; never more than one bit set.
REQ-007 grant_valid  output  1  high iff grant != 0, registered.
REQ-008 grant_id  output  2  index of the granted master; 0 when grant_valid is low.
REQ-009 timeout  output  1  one-cycle pulse on forced release.

Function
REQ-010 FSM states SHALL be IDLE, GRANT and HANDOVER.
REQ-011 IDLE: req == 0 -> stay; otherwise -> GRANT, winner taken from the round-robin pick.
REQ-012 Latency SHALL be one cycle: req sampled at edge N gives grant high after edge N.
REQ-013 Round-robin pick SHALL search upward from (last_id+1) mod 4, wrapping, and select the first set req bit.
REQ-014 last_id SHALL update to the winner when a grant is issued.
REQ-015 GRANT: req[grant_id] high -> stay, grant stable.
REQ-016 GRANT: req[grant_id] low -> HANDOVER, grant cleared at that same edge.
REQ-017 HANDOVER SHALL last exactly one cycle with grant == 0, then -> GRANT if any req (new pick), else -> IDLE.
REQ-018 Requests from non-granted masters SHALL be ignored in GRANT; there is no preemption except by REQ-021.
REQ-019 A master that re-asserts req immediately after release SHALL be granted again only if no other master requests.

Reset
REQ-020 reset_n low at any clock edge, including mid-GRANT, SHALL force IDLE, grant=0, grant_valid=0, grant_id=0, timeout=0, hold counter=0 and last_id=3, so master 0 has first priority.

Configuration
REQ-021 With macro DMA_ARB_TIMEOUT_EN defined, the counter behaves as follows:
- The hold counter SHALL clear on entry to GRANT and increment each cycle in GRANT.
- If the counter equals HOLD_MAX while req[grant_id] is still high, the block SHALL go to HANDOVER, clear grant, and pulse timeout for one cycle.
- last_id keeps the timed-out master, so it loses priority.
REQ-022 If req[grant_id] falls on the same cycle the counter reaches HOLD_MAX, the block SHALL treat it as a normal release with no timeout pulse.
REQ-023 Without DMA_ARB_TIMEOUT_EN, the hold counter SHALL be absent, the timeout port SHALL remain and be tied to 0, and a grant is held indefinitely.

Structure
REQ-024 A shared package/include SHALL hold the state encodings (IDLE=2'b00, GRANT=2'b01, HANDOVER=2'b10), NUM_REQ=4 and the grant_id width.
REQ-025 A combinational sub-module rr_pick SHALL take (req, last_id) and return (any, winner_id, winner_onehot); dma_bus_arbiter SHALL instantiate it once.
REQ-026 All outputs SHALL come directly from flops.

Verification
REQ-027 Reset, then req=4'b0001 held -> grant=0001, grant_id=0 one cycle later, stable while req[0]=1.
REQ-028 req=4'b1111 held, each master dropping its req after 3 cycles granted -> grant order 0,1,2,3 with exactly one zero-grant HANDOVER cycle between grants.
REQ-029 Master 2 granted (last_id=2), then req=4'b0101 -> next grant goes to master 0 (wrap-around).
REQ-030 With DMA_ARB_TIMEOUT_EN and HOLD_MAX=15, req[1] held for 40 cycles alone:
- After 15 cycles in GRANT: timeout pulse and grant=0 for one cycle.
- Then master 1 is re-granted, since no other master requests.
- Same run with req[3] also high -> master 3 is granted after the timeout.
REQ-031 reset_n driven low for one cycle during GRANT -> next edge grant=0, state IDLE; then req=4'b1000 -> grant is issued after one cycle.
REQ-032 Check every cycle that grant is one-hot or zero, and that grant_valid and grant_id are consistent with grant.
